// File: rtl/vid_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vid_timing_pkg
// Description : Video mode timing table, mode index type and helpers that
//               turn a table entry into per-axis decode bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package vid_timing_pkg;

    localparam int TBL_W     = 12;
    localparam int TBL_MODES = 4;

    localparam logic POL_NEG = 1'b0;
    localparam logic POL_POS = 1'b1;

    typedef enum logic [1:0] {
        MODE_640X480   = 2'd0,
        MODE_1920X1080 = 2'd1,
        MODE_1280X720  = 2'd2,
        MODE_800X600   = 2'd3
    } mode_idx_t;

    typedef struct packed {
        logic [TBL_W-1:0] h_act;
        logic [TBL_W-1:0] h_fp;
        logic [TBL_W-1:0] h_sync;
        logic [TBL_W-1:0] h_bp;
        logic [TBL_W-1:0] h_tot;
        logic [TBL_W-1:0] v_act;
        logic [TBL_W-1:0] v_fp;
        logic [TBL_W-1:0] v_sync;
        logic [TBL_W-1:0] v_bp;
        logic [TBL_W-1:0] v_tot;
        logic             hpol;
        logic             vpol;
    } timing_t;

    // Decode bounds for one axis: active is [0, act), sync is [sync_beg, sync_end).
    typedef struct packed {
        logic [TBL_W-1:0] act;
        logic [TBL_W-1:0] sync_beg;
        logic [TBL_W-1:0] sync_end;
        logic [TBL_W-1:0] last;
    } axis_bounds_t;

    localparam timing_t MODE_TABLE [TBL_MODES] = '{
        '{12'd640,  12'd16,  12'd96,  12'd48,  12'd800,
          12'd480,  12'd10,  12'd2,   12'd33,  12'd525,  POL_NEG, POL_NEG},
        '{12'd1920, 12'd88,  12'd44,  12'd148, 12'd2200,
          12'd1080, 12'd4,   12'd5,   12'd36,  12'd1125, POL_POS, POL_POS},
        '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd1650,
          12'd720,  12'd5,   12'd5,   12'd20,  12'd750,  POL_POS, POL_POS},
        '{12'd800,  12'd40,  12'd128, 12'd88,  12'd1056,
          12'd600,  12'd1,   12'd4,   12'd23,  12'd628,  POL_POS, POL_POS}
    };

    localparam logic [TBL_W-1:0] TBL_ONE = {{(TBL_W-1){1'b0}}, 1'b1};

    // Full decode bounds of one axis of a mode; vert selects the vertical axis.
    function automatic axis_bounds_t axis_bounds(input mode_idx_t m, input logic vert);
        axis_bounds_t b;
        if (vert) begin
            b.act      = MODE_TABLE[m].v_act;
            b.sync_beg = MODE_TABLE[m].v_act + MODE_TABLE[m].v_fp;
            b.sync_end = MODE_TABLE[m].v_act + MODE_TABLE[m].v_fp + MODE_TABLE[m].v_sync;
            b.last     = MODE_TABLE[m].v_tot - TBL_ONE;
        end else begin
            b.act      = MODE_TABLE[m].h_act;
            b.sync_beg = MODE_TABLE[m].h_act + MODE_TABLE[m].h_fp;
            b.sync_end = MODE_TABLE[m].h_act + MODE_TABLE[m].h_fp + MODE_TABLE[m].h_sync;
            b.last     = MODE_TABLE[m].h_tot - TBL_ONE;
        end
        return b;
    endfunction

    // Last coordinate of one axis, used to detect the wrap point.
    function automatic logic [TBL_W-1:0] axis_last(input mode_idx_t m, input logic vert);
        return vert ? (MODE_TABLE[m].v_tot - TBL_ONE) : (MODE_TABLE[m].h_tot - TBL_ONE);
    endfunction

    // Sync polarity of one axis (1 = active high).
    function automatic logic axis_pol(input mode_idx_t m, input logic vert);
        return vert ? MODE_TABLE[m].vpol : MODE_TABLE[m].hpol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vid_timing_gen_if
// Description : Control inputs and timing outputs of the video timing
//               generator. master = generator, slave = display pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface vid_timing_gen_if #(
    parameter int CORDW  = 12,
    parameter int MODE_W = 2
);
    logic              pix_en;
    logic [MODE_W-1:0] res;
    logic [CORDW-1:0]  sx;
    logic [CORDW-1:0]  sy;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              frame_start;
    logic              line_start;
    logic [MODE_W-1:0] mode_cur;
    logic              mode_chg;

    modport master (
        input  pix_en, res,
        output sx, sy, hsync, vsync, de, frame_start, line_start, mode_cur, mode_chg
    );

    modport slave (
        output pix_en, res,
        input  sx, sy, hsync, vsync, de, frame_start, line_start, mode_cur, mode_chg
    );
endinterface
`default_nettype wire

// File: rtl/vid_axis_ctr.sv
`default_nettype none
// ============================================================================
// Module      : vid_axis_ctr
// Description : One axis of the timing generator. Produces the next count
//               (wrapping at the current mode's total, or loaded with the
//               last coordinate of the next mode) and decodes active/sync
//               for that next count against the next mode's bounds.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_axis_ctr #(
    parameter int CORDW = 12
) (
    input  logic [CORDW-1:0] count,
    input  logic             inc,
    input  logic             load,
    input  logic [CORDW-1:0] cur_last,
    input  logic [CORDW-1:0] nxt_act,
    input  logic [CORDW-1:0] nxt_sync_beg,
    input  logic [CORDW-1:0] nxt_sync_end,
    input  logic [CORDW-1:0] nxt_last,
    output logic [CORDW-1:0] count_nxt,
    output logic             wrap,
    output logic             active,
    output logic             sync
);
    localparam logic [CORDW-1:0] c_one = {{(CORDW-1){1'b0}}, 1'b1};

    // Wrap is judged in the mode in effect; load parks on the last pixel.
    always_comb begin
        wrap      = (count == cur_last);
        count_nxt = count;
        if (load) begin
            count_nxt = nxt_last;
        end else if (inc) begin
            count_nxt = wrap ? '0 : (count + c_one);
        end
    end

    // Decode the coordinate that is about to be registered.
    always_comb begin
        active = (count_nxt < nxt_act);
        sync   = (count_nxt >= nxt_sync_beg) && (count_nxt < nxt_sync_end);
    end
endmodule
`default_nettype wire

// File: rtl/vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vid_timing_gen
// Description : Multi-mode video timing generator. Counters advance on
//               pix_en; mode is sampled only at the frame wrap; all outputs
//               are registered from the decode of the next pixel so they all
//               describe the same (sx, sy).
// Revision    : 1.0 - initial release
// ============================================================================
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int CORDW  = 12,
    parameter int NMODES = 4,
    parameter int MODE_W = 2
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    vid_timing_gen_if.master vif
);
    localparam logic [MODE_W:0] c_nmodes = (MODE_W+1)'(NMODES);

    logic [CORDW-1:0]  r_sx;
    logic [CORDW-1:0]  r_sy;
    logic [MODE_W-1:0] r_mode;
    logic              r_de;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_frame_start;
    logic              r_line_start;
    logic              r_mode_chg;

    logic              w_res_ok;
    logic              w_frame_wrap;
    logic [MODE_W-1:0] w_mode_nxt;
    logic              w_chg_nxt;
    mode_idx_t         w_cur_idx;
    mode_idx_t         w_nxt_idx;
    axis_bounds_t      w_nxt_hb;
    axis_bounds_t      w_nxt_vb;
    logic [CORDW-1:0]  w_cur_hlast;
    logic [CORDW-1:0]  w_cur_vlast;
    logic              w_nxt_hpol;
    logic              w_nxt_vpol;
    logic [CORDW-1:0]  w_sx_nxt;
    logic [CORDW-1:0]  w_sy_nxt;
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic              w_h_act;
    logic              w_v_act;
    logic              w_h_sync;
    logic              w_v_sync;
    logic              w_v_inc;

    // Table lookups for the mode in effect and the mode of the next pixel.
    always_comb begin
        w_cur_idx   = mode_idx_t'(2'(r_mode));
        w_nxt_idx   = mode_idx_t'(2'(w_mode_nxt));
        w_cur_hlast = CORDW'(axis_last(w_cur_idx, 1'b0));
        w_cur_vlast = CORDW'(axis_last(w_cur_idx, 1'b1));
        w_nxt_hb    = axis_bounds(w_nxt_idx, 1'b0);
        w_nxt_vb    = axis_bounds(w_nxt_idx, 1'b1);
        w_nxt_hpol  = axis_pol(w_nxt_idx, 1'b0);
        w_nxt_vpol  = axis_pol(w_nxt_idx, 1'b1);
    end

    // Mode selection: reset loads res, otherwise res is only honoured at the frame wrap.
    always_comb begin
        w_res_ok     = ({1'b0, vif.res} < c_nmodes);
        w_frame_wrap = vif.pix_en && w_h_wrap && w_v_wrap;
        w_mode_nxt   = r_mode;
        if (rst_pix) begin
            w_mode_nxt = w_res_ok ? vif.res : '0;
        end else if (w_frame_wrap && w_res_ok) begin
            w_mode_nxt = vif.res;
        end
        w_chg_nxt = !rst_pix && w_frame_wrap && (w_mode_nxt != r_mode);
    end

    assign w_v_inc = vif.pix_en && w_h_wrap;

    vid_axis_ctr #(
        .CORDW (CORDW)
    ) u_h_ctr (
        .count        (r_sx),
        .inc          (vif.pix_en),
        .load         (rst_pix),
        .cur_last     (w_cur_hlast),
        .nxt_act      (CORDW'(w_nxt_hb.act)),
        .nxt_sync_beg (CORDW'(w_nxt_hb.sync_beg)),
        .nxt_sync_end (CORDW'(w_nxt_hb.sync_end)),
        .nxt_last     (CORDW'(w_nxt_hb.last)),
        .count_nxt    (w_sx_nxt),
        .wrap         (w_h_wrap),
        .active       (w_h_act),
        .sync         (w_h_sync)
    );

    vid_axis_ctr #(
        .CORDW (CORDW)
    ) u_v_ctr (
        .count        (r_sy),
        .inc          (w_v_inc),
        .load         (rst_pix),
        .cur_last     (w_cur_vlast),
        .nxt_act      (CORDW'(w_nxt_vb.act)),
        .nxt_sync_beg (CORDW'(w_nxt_vb.sync_beg)),
        .nxt_sync_end (CORDW'(w_nxt_vb.sync_end)),
        .nxt_last     (CORDW'(w_nxt_vb.last)),
        .count_nxt    (w_sy_nxt),
        .wrap         (w_v_wrap),
        .active       (w_v_act),
        .sync         (w_v_sync)
    );

    // State and output registers: update on reset or enabled pixel, hold otherwise.
    always_ff @(posedge clk_pix) begin
        if (rst_pix || vif.pix_en) begin
            r_sx          <= w_sx_nxt;
            r_sy          <= w_sy_nxt;
            r_mode        <= w_mode_nxt;
            r_de          <= w_h_act && w_v_act;
            r_hsync       <= w_h_sync ~^ w_nxt_hpol;
            r_vsync       <= w_v_sync ~^ w_nxt_vpol;
            r_frame_start <= (w_sx_nxt == '0) && (w_sy_nxt == '0);
            r_line_start  <= (w_sx_nxt == '0);
            r_mode_chg    <= w_chg_nxt;
        end
    end

    assign vif.sx          = r_sx;
    assign vif.sy          = r_sy;
    assign vif.mode_cur    = r_mode;
    assign vif.de          = r_de;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.frame_start = r_frame_start;
    assign vif.line_start  = r_line_start;
    assign vif.mode_chg    = r_mode_chg;
endmodule
`default_nettype wire

// File: tb/tb_vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_timing_gen
// Description : Self-checking bench for vid_timing_gen. Two instances
//               (NMODES = 4 and NMODES = 3) share stimulus; a frame-index
//               reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_timing_gen;

    localparam int M_HA [4] = '{640, 1920, 1280, 800};
    localparam int M_HF [4] = '{16, 88, 110, 40};
    localparam int M_HS [4] = '{96, 44, 40, 128};
    localparam int M_HT [4] = '{800, 2200, 1650, 1056};
    localparam int M_VA [4] = '{480, 1080, 720, 600};
    localparam int M_VF [4] = '{10, 4, 5, 1};
    localparam int M_VS [4] = '{2, 5, 5, 4};
    localparam int M_VT [4] = '{525, 1125, 750, 628};
    localparam int M_POL [4] = '{0, 1, 1, 1};
    localparam int NM [2] = '{4, 3};

    logic clk;
    logic rst_pix;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: pixel index within the frame, mode, mode_chg.
    int m_p    [2];
    int m_mode [2];
    int m_chg  [2];

    vid_timing_gen_if #(.CORDW(12), .MODE_W(2)) vif4 ();
    vid_timing_gen_if #(.CORDW(12), .MODE_W(2)) vif3 ();

    vid_timing_gen #(.CORDW(12), .NMODES(4), .MODE_W(2)) dut4 (
        .clk_pix (clk),
        .rst_pix (rst_pix),
        .vif     (vif4)
    );

    vid_timing_gen #(.CORDW(12), .NMODES(3), .MODE_W(2)) dut3 (
        .clk_pix (clk),
        .rst_pix (rst_pix),
        .vif     (vif3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_one(input int k, input string pfx,
                               input logic [11:0] sx, input logic [11:0] sy,
                               input logic hs, input logic vs, input logic de,
                               input logic fs, input logic ls,
                               input logic [1:0] mc, input logic chg);
        int md, x, y, hb, vb;
        bit has, vas;
        md  = m_mode[k];
        x   = m_p[k] % M_HT[md];
        y   = m_p[k] / M_HT[md];
        hb  = M_HA[md] + M_HF[md];
        vb  = M_VA[md] + M_VF[md];
        has = (x >= hb) && (x < hb + M_HS[md]);
        vas = (y >= vb) && (y < vb + M_VS[md]);
        check({pfx, ".sx"},    32'(sx),  32'(x));
        check({pfx, ".sy"},    32'(sy),  32'(y));
        check({pfx, ".de"},    32'(de),  32'((x < M_HA[md]) && (y < M_VA[md])));
        check({pfx, ".hsync"}, 32'(hs),  32'((M_POL[md] == 1) ? has : !has));
        check({pfx, ".vsync"}, 32'(vs),  32'((M_POL[md] == 1) ? vas : !vas));
        check({pfx, ".fstart"},32'(fs),  32'(m_p[k] == 0));
        check({pfx, ".lstart"},32'(ls),  32'(x == 0));
        check({pfx, ".mode"},  32'(mc),  32'(md));
        check({pfx, ".chg"},   32'(chg), 32'(m_chg[k]));
    endtask

    task automatic model_update(input bit r, input bit en, input int rs);
        for (int k = 0; k < 2; k++) begin
            int frame_len, nmode;
            frame_len = M_HT[m_mode[k]] * M_VT[m_mode[k]];
            if (r) begin
                m_mode[k] = (rs < NM[k]) ? rs : 0;
                m_p[k]    = M_HT[m_mode[k]] * M_VT[m_mode[k]] - 1;
                m_chg[k]  = 0;
            end else if (en) begin
                m_p[k]   = (m_p[k] + 1) % frame_len;
                m_chg[k] = 0;
                if (m_p[k] == 0) begin
                    nmode     = (rs < NM[k]) ? rs : m_mode[k];
                    m_chg[k]  = (nmode != m_mode[k]) ? 1 : 0;
                    m_mode[k] = nmode;
                end
            end
        end
    endtask

    // One clock: drive inputs, clock, then predict and compare both instances.
    task automatic step(input bit r, input bit en, input int rs);
        if (failures > 200) return;
        rst_pix     = r;
        vif4.pix_en = en;
        vif3.pix_en = en;
        vif4.res    = 2'(rs);
        vif3.res    = 2'(rs);
        @(posedge clk);
        #1;
        model_update(r, en, rs);
        compare_one(0, "d4", vif4.sx, vif4.sy, vif4.hsync, vif4.vsync, vif4.de,
                    vif4.frame_start, vif4.line_start, vif4.mode_cur, vif4.mode_chg);
        compare_one(1, "d3", vif3.sx, vif3.sy, vif3.hsync, vif3.vsync, vif3.de,
                    vif3.frame_start, vif3.line_start, vif3.mode_cur, vif3.mode_chg);
    endtask

    initial begin
        int len, dens, rsel;
        rst_pix     = 1'b1;
        vif4.pix_en = 1'b0;
        vif3.pix_en = 1'b0;
        vif4.res    = 2'd0;
        vif3.res    = 2'd0;

        // Mode 0: reset state, first pixel, two full lines plus a bit.
        step(1, 0, 0);
        check("m0.rst.sx", 32'(vif4.sx), 32'd799);
        check("m0.rst.sy", 32'(vif4.sy), 32'd524);
        check("m0.rst.de", 32'(vif4.de), 32'd0);
        check("m0.rst.hs", 32'(vif4.hsync), 32'd1);
        step(0, 1, 0);
        check("m0.first.de", 32'(vif4.de), 32'd1);
        check("m0.first.fs", 32'(vif4.frame_start), 32'd1);
        for (int i = 0; i < 1700; i++) step(0, 1, 0);

        // Mid-frame reset with pix_en high: reset wins, parks on last pixel.
        step(1, 1, 0);
        check("midrst.sx", 32'(vif4.sx), 32'd799);
        check("midrst.sy", 32'(vif4.sy), 32'd524);
        check("midrst.vs", 32'(vif4.vsync), 32'd1);
        step(0, 0, 0);
        step(0, 1, 0);
        check("midrst.fs", 32'(vif4.frame_start), 32'd1);

        // Mode 1 with res changing every cycle mid-frame (must be ignored).
        step(1, 1, 1);
        step(0, 1, 1);
        for (int i = 0; i < 4500; i++) step(0, 1, int'($urandom_range(0, 3)));

        // Mode 3 with pix_en 1-on/2-off over two lines.
        step(1, 0, 3);
        for (int i = 0; i < 3 * 2 * 1056 + 60; i++) step(0, (i % 3) == 0, 3);

        // Wrap-time mode switch 2 -> 0, line 0 then runs at 800-pixel timing.
        step(1, 1, 2);
        step(0, 1, 0);
        check("sw.d4.mode", 32'(vif4.mode_cur), 32'd0);
        check("sw.d4.chg",  32'(vif4.mode_chg), 32'd1);
        step(0, 0, 1);
        check("sw.d4.chghold", 32'(vif4.mode_chg), 32'd1);
        for (int i = 0; i < 900; i++) step(0, 1, int'($urandom_range(0, 3)));

        // Unsupported mode request: NMODES=3 instance keeps mode 2.
        step(1, 1, 2);
        step(0, 1, 3);
        check("bad.d3.mode", 32'(vif3.mode_cur), 32'd2);
        check("bad.d3.chg",  32'(vif3.mode_chg), 32'd0);
        check("bad.d4.mode", 32'(vif4.mode_cur), 32'd3);
        for (int i = 0; i < 1800; i++) step(0, 1, 3);

        // Reset with res out of range for the NMODES=3 instance falls back to 0.
        step(1, 1, 3);
        check("rst3.d3.mode", 32'(vif3.mode_cur), 32'd0);

        // Random segments: random mode, enable density, switch and rare resets.
        for (int s = 0; s < 10; s++) begin
            step(1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
            step(0, 1, int'($urandom_range(0, 3)));
            len  = int'($urandom_range(500, 3000));
            dens = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                rsel = int'($urandom_range(0, 3));
                step($urandom_range(0, 1999) == 0, int'($urandom_range(0, 3)) < dens, rsel);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
